// File: rtl/aftab_shift_pkg.sv
// ============================================================================
// Module      : aftab_shift_pkg
// Description : Shift mode and sequencer state encodings shared by the
//               sequential shifter and the multiplier/divider control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aftab_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

`default_nettype wire

// File: rtl/aftab_down_counter.sv
// ============================================================================
// Module      : aftab_down_counter
// Description : Loadable down counter holding the remaining shift steps,
//               with a flag marking the last step (count == 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aftab_down_counter #(
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [AMT_W-1:0] load_val_i,
  output logic             tc_one_o
);

  logic [AMT_W-1:0] cnt_q;
  logic [AMT_W-1:0] cnt_d;

  // Next count: clear wins over load, load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (init_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - AMT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_one_o = (cnt_q == AMT_W'(1));

endmodule

`default_nettype wire

// File: rtl/aftab_seq_shift_register.sv
// ============================================================================
// Module      : aftab_seq_shift_register
// Description : Bit-serial shifter: one bit per clock for SLL/SRL/SRA/ROR,
//               with busy while shifting and a one-cycle done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aftab_seq_shift_register
  import aftab_shift_pkg::*;
#(
  parameter int size  = 32,
  parameter int AMT_W = $clog2(size)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             start,
  input  logic [size-1:0]  dataIn,
  input  logic [AMT_W-1:0] shamt,
  input  logic [1:0]       mode,
  output logic [size-1:0]  dataOut,
  output logic             serOut,
  output logic             busy,
  output logic             done
);

  shift_state_e state_q, state_d;
  shift_mode_e  mode_q,  mode_d;
  logic [size-1:0] data_q, data_d;
  logic            ser_q,  ser_d;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_last;

  aftab_down_counter #(
    .AMT_W (AMT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .init_i     (init),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (shamt),
    .tc_one_o   (cnt_last)
  );

  // Next-state, datapath and counter control; init overrides everything.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    data_d   = data_q;
    ser_d    = ser_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (init) begin
      state_d = ST_IDLE;
      data_d  = '0;
      ser_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          cnt_dec = 1'b1;
          case (mode_q)
            MODE_SLL: begin
              data_d = {data_q[size-2:0], 1'b0};
              ser_d  = data_q[size-1];
            end
            MODE_SRL: begin
              data_d = {1'b0, data_q[size-1:1]};
              ser_d  = data_q[0];
            end
            MODE_SRA: begin
              data_d = {data_q[size-1], data_q[size-1:1]};
              ser_d  = data_q[0];
            end
            default: begin
              data_d = {data_q[0], data_q[size-1:1]};
              ser_d  = data_q[0];
            end
          endcase
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, so DONE can chain
          // straight into the next operation without an idle bubble.
          if (start) begin
            data_d   = dataIn;
            ser_d    = 1'b0;
            mode_d   = shift_mode_e'(mode);
            cnt_load = 1'b1;
            state_d  = (shamt != '0) ? ST_SHIFT : ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // State, latched mode and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SLL;
      data_q  <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
    end
  end

  // Status decoded purely from registered state.
  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);
  assign dataOut = data_q;
  assign serOut  = ser_q;

endmodule

`default_nettype wire
